// File: rtl/jpeg_rle_pkg.sv
// Shared types and constants for the JPEG zero-run-length symbol encoder.
package jpeg_rle_pkg;

  typedef enum logic [1:0] {
    ACCEPT   = 2'd0,
    EMIT_ZRL = 2'd1,
    EMIT_SYM = 2'd2,
    EMIT_EOB = 2'd3
  } rle_state_e;

  localparam logic [3:0] ZRL_RUN = 4'd15;
  localparam int         BLK_LEN = 64;

  // Internal symbol fields are wide enough for any supported SW/AW; the top narrows them.
  localparam int RLE_SW = 8;
  localparam int RLE_AW = 16;

  typedef struct packed {
    logic [3:0]        run;
    logic [RLE_SW-1:0] size;
    logic [RLE_AW-1:0] amp;
    logic              dc;
    logic              eob;
  } rle_sym_t;

endpackage

// File: rtl/jpeg_size_cat.sv
// Combinational JPEG magnitude category: signed value -> {size, amplitude bits}.
module jpeg_size_cat #(
  parameter int VW = 12,
  parameter int SW = 4,
  parameter int AW = 12
) (
  input  logic [VW-1:0] val,
  output logic [SW-1:0] size,
  output logic [AW-1:0] amp
);

  localparam int MW = (VW < AW) ? VW : AW;

  logic [VW-1:0] mag;
  logic [VW-1:0] amp_full;

  // Negative values use the one's-complement amplitude (v-1), masked to size bits.
  always_comb begin
    mag      = val[VW-1] ? (~val + VW'(1)) : val;
    amp_full = val[VW-1] ? (val - VW'(1))  : val;
    size     = '0;
    for (int i = 0; i < VW; i++) begin
      if (mag[i]) size = SW'(i + 1);
    end
    amp = '0;
    for (int i = 0; i < MW; i++) begin
      if (i < int'(size)) amp[i] = amp_full[i];
    end
  end

endmodule

// File: rtl/jpeg_zrl_encoder.sv
// Run-length symbol encoder (DC, RUN/SIZE/AMP, ZRL, EOB) with a one-symbol output register.
// Optional feature macro: JPEG_RLE_DC_DIFF_EN (DC encoded as difference to previous block DC).
module jpeg_zrl_encoder
  import jpeg_rle_pkg::*;
#(
  parameter int CW = 12,
  parameter int SW = 4,
  parameter int AW = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coef_valid,
  output logic                 coef_ready,
  input  logic signed [CW-1:0] coef_data,
  output logic                 sym_valid,
  input  logic                 sym_ready,
  output logic [3:0]           sym_run,
  output logic [SW-1:0]        sym_size,
  output logic [AW-1:0]        sym_amp,
  output logic                 sym_dc,
  output logic                 sym_eob
);

  rle_state_e state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] run_q, run_d;
  logic [1:0] zrl_q, zrl_d;
  rle_sym_t   sym_q, sym_d;
  rle_sym_t   lat_q, lat_d;
  logic       sym_valid_q, sym_valid_d;

  logic       load_ok;
  logic       fire;
  logic [SW-1:0] cat_size;
  logic [AW-1:0] cat_amp;
  rle_sym_t   ac_sym, zrl_sym, eob_sym;

`ifdef JPEG_RLE_DC_DIFF_EN
  localparam int VW = CW + 1;
  logic [CW-1:0] prev_dc_q, prev_dc_d;
  logic [VW-1:0] dc_ref;
  logic [VW-1:0] cat_val;
  assign dc_ref  = (idx_q == 6'd0) ? {prev_dc_q[CW-1], prev_dc_q} : '0;
  assign cat_val = {coef_data[CW-1], coef_data} - dc_ref;

  always_comb begin
    prev_dc_d = prev_dc_q;
    if (fire && (idx_q == 6'd0)) prev_dc_d = coef_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_dc_q <= '0;
    else     prev_dc_q <= prev_dc_d;
  end
`else
  localparam int VW = CW;
  logic [VW-1:0] cat_val;
  assign cat_val = coef_data;
`endif

  jpeg_size_cat #(.VW(VW), .SW(SW), .AW(AW)) u_size_cat (
    .val  (cat_val),
    .size (cat_size),
    .amp  (cat_amp)
  );

  assign load_ok    = !sym_valid_q || sym_ready;
  assign coef_ready = !rst && (state_q == ACCEPT) && load_ok;
  assign fire       = coef_valid && coef_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    run_d       = run_q;
    zrl_d       = zrl_q;
    lat_d       = lat_q;
    sym_d       = sym_q;
    sym_valid_d = sym_valid_q && !sym_ready;

    ac_sym      = '0;
    ac_sym.run  = run_q[3:0];
    ac_sym.size = RLE_SW'(cat_size);
    ac_sym.amp  = RLE_AW'(cat_amp);
    zrl_sym     = '0;
    zrl_sym.run = ZRL_RUN;
    eob_sym     = '0;
    eob_sym.eob = 1'b1;

    case (state_q)
      ACCEPT: begin
        if (fire) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd0) begin
            sym_d       = ac_sym;
            sym_d.run   = 4'd0;
            sym_d.dc    = 1'b1;
            sym_valid_d = 1'b1;
            run_d       = 6'd0;
          end else if (coef_data == '0) begin
            run_d = run_q + 6'd1;
            if (idx_q == 6'(BLK_LEN - 1)) state_d = EMIT_EOB;
          end else if (run_q < 6'd16) begin
            sym_d       = ac_sym;
            sym_valid_d = 1'b1;
            run_d       = 6'd0;
          end else begin
            // The slot is free now, so the first ZRL goes out with the accept itself.
            lat_d       = ac_sym;
            sym_d       = zrl_sym;
            sym_valid_d = 1'b1;
            zrl_d       = run_q[5:4] - 2'd1;
            run_d       = {2'b00, run_q[3:0]};
            state_d     = (run_q[5:4] == 2'd1) ? EMIT_SYM : EMIT_ZRL;
          end
        end
      end
      EMIT_ZRL: begin
        if (load_ok) begin
          sym_d       = zrl_sym;
          sym_valid_d = 1'b1;
          zrl_d       = zrl_q - 2'd1;
          if (zrl_q == 2'd1) state_d = EMIT_SYM;
        end
      end
      EMIT_SYM: begin
        if (load_ok) begin
          sym_d       = lat_q;
          sym_valid_d = 1'b1;
          run_d       = 6'd0;
          state_d     = ACCEPT;
        end
      end
      EMIT_EOB: begin
        if (load_ok) begin
          sym_d       = eob_sym;
          sym_valid_d = 1'b1;
          run_d       = 6'd0;
          state_d     = ACCEPT;
        end
      end
      default: begin
        state_d = ACCEPT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCEPT;
      idx_q       <= 6'd0;
      run_q       <= 6'd0;
      zrl_q       <= 2'd0;
      lat_q       <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      zrl_q       <= zrl_d;
      lat_q       <= lat_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_run   = sym_q.run;
  assign sym_size  = SW'(sym_q.size);
  assign sym_amp   = AW'(sym_q.amp);
  assign sym_dc    = sym_q.dc;
  assign sym_eob   = sym_q.eob;

endmodule
